alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester tag carried from request to response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-006 reqN_func  input  4  (N=0,1) ALU operation code.
REQ-007 reqN_a, reqN_b  input  32 each  (N=0,1) operands.
REQ-008 reqN_tag  input  TAG_W  (N=0,1) opaque requester tag.
REQ-009 resp_valid  output  1  response buffer head valid.
REQ-010 resp_ready  input  1  consumer accepts head.
REQ-011 resp_out  output  32  ALU result.
REQ-012 resp_id  output  1  index of the originating requester.
REQ-013 resp_tag  output  TAG_W  tag of the originating request.
REQ-014 resp_err  output  1  func code was illegal (4'b1001-4'b1111).

Function
REQ-015 Transfer on each port occurs when valid and ready are both high in the same cycle.
REQ-016 At most one request is accepted per cycle; the single shared ALU is evaluated only for the granted request.
REQ-017 Arbitration: round-robin; with both valid, grant the port not granted last; with one valid, grant it; last-grant pointer updates only on an accepted transfer.
REQ-018 reqN_ready is high only for the granted port, and only when space exists (buffer not full, or full with resp_ready high this cycle).
REQ-019 reqN_ready depends on neither port's func, a, b or tag.
REQ-020 Latency: an accepted operation appears at resp_* on the next cycle at the earliest; responses are returned in acceptance order.
REQ-021 Illegal func: resp_out = 32'h0, resp_err = 1, and the request is still consumed and ordered normally.
REQ-022 Buffer states: EMPTY, ONE and (with skid) TWO; accept-only moves up one state, drain-only moves down one, simultaneous accept and drain holds.
REQ-023 Response fields stay stable while resp_valid is high and resp_ready is low.
REQ-024 Idle inputs (no valid) leave all state unchanged.

Reset
REQ-025 resetn low: buffer EMPTY, resp_valid=0, resp_out=0, resp_id=0, resp_tag=0, resp_err=0, last-grant pointer=1 (port 0 wins first tie), both ready=0.
REQ-026 Reset mid-operation discards all buffered responses without emitting them; the first acceptance after release is port 0 under contention.

Configuration
REQ-027 Macro ALU_ARBITER_SKID_EN defined: response buffer depth 2 (states EMPTY/ONE/TWO), so full throughput is sustained with one cycle of resp_ready bubble.
REQ-028 Macro undefined: depth 1 (EMPTY/ONE); acceptance when ONE requires same-cycle drain; TWO state absent.

Structure
REQ-029 Shared package holds ALU func-code constants (NOR, SRA, SRL, ADD, SUB, SLT, AND, OR, XOR), the illegal-code bound 4'b1001, and the response-entry struct (out, id, tag, err).
REQ-030 Sub-module: one instance of the existing alu; request mux, arbiter and response buffer live in alu_arbiter.

Verification
REQ-031 Only req0 valid, func=ADD, a=5, b=7, tag=3, resp_ready=1 -> next cycle resp_out=12, resp_id=0, resp_tag=3, resp_err=0.
REQ-032 Both valid continuously for 4 accepts after reset, resp_ready=1 -> grants 0,1,0,1; resp_id sequence 0,1,0,1.
REQ-033 req1 func=4'b1100, a=1, b=1 -> resp_out=0, resp_err=1, resp_id=1.
REQ-034 resp_ready=0 with both requesting -> skid: two accepts then both ready low; no skid: one accept; held resp_* stable; resp_ready=1 drains in order.
REQ-035 Assert resetn low while buffer holds entries -> resp_valid=0 asynchronously; after release, contention grants port 0.
REQ-036 req0 func=SUB, a=0, b=1 -> resp_out=32'hFFFF_FFFF; func=SLT, a=3, b=9 -> resp_out=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes, response-buffer states and response-entry layout for alu_arbiter.
package alu_arbiter_pkg;

    localparam logic [3:0] FN_NOR = 4'd0;
    localparam logic [3:0] FN_SRA = 4'd1;
    localparam logic [3:0] FN_SRL = 4'd2;
    localparam logic [3:0] FN_ADD = 4'd3;
    localparam logic [3:0] FN_SUB = 4'd4;
    localparam logic [3:0] FN_SLT = 4'd5;
    localparam logic [3:0] FN_AND = 4'd6;
    localparam logic [3:0] FN_OR  = 4'd7;
    localparam logic [3:0] FN_XOR = 4'd8;
    localparam logic [3:0] FN_ILLEGAL_MIN = 4'b1001;

    // Tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
    localparam int RESP_TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [31:0]               out;
        logic                      id;
        logic [RESP_TAG_W_MAX-1:0] tag;
        logic                      err;
    } resp_ent_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; zero latency, no flow control. Codes 9..15 give 0 with o_err set.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  i_func,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_out,
    output logic        o_err
);

    always_comb begin
        o_out = 32'd0;
        o_err = (i_func >= FN_ILLEGAL_MIN);
        case (i_func)
            FN_NOR:  o_out = ~(i_a | i_b);
            FN_SRA:  o_out = $unsigned($signed(i_a) >>> i_b[4:0]);
            FN_SRL:  o_out = i_a >> i_b[4:0];
            FN_ADD:  o_out = i_a + i_b;
            FN_SUB:  o_out = i_a - i_b;
            FN_SLT:  o_out = {31'd0, ($signed(i_a) < $signed(i_b))};
            FN_AND:  o_out = i_a & i_b;
            FN_OR:   o_out = i_a | i_b;
            FN_XOR:  o_out = i_a ^ i_b;
            default: o_out = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end to one shared ALU; results 1 cycle after accept, in order.
// Ready is withheld when the response buffer is full and not draining; ALU_ARBITER_SKID_EN deepens the buffer to 2.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_func,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_func,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_out,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err
);

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    resp_ent_t        r_head;
    resp_ent_t        w_new;
    logic             r_last;
    logic             w_gnt;
    logic             w_full;
    logic             w_space;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_func;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_alu_out;
    logic             w_alu_err;

`ifdef ALU_ARBITER_SKID_EN
    resp_ent_t        r_tail;
    assign w_full = (r_state == BUF_TWO);
`else
    assign w_full = (r_state == BUF_ONE);
`endif

    // A full buffer still has room when its head leaves this cycle.
    assign w_space = resetn && (!w_full || resp_ready);

    // Contention goes to the port not granted last; otherwise the lone requester wins.
    assign w_gnt      = (req0_valid && req1_valid) ? ~r_last : ~req0_valid;
    assign req0_ready = w_space && req0_valid && !w_gnt;
    assign req1_ready = w_space && req1_valid && w_gnt;

    assign w_push = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_pop  = resp_valid && resp_ready;

    assign w_func = w_gnt ? req1_func : req0_func;
    assign w_a    = w_gnt ? req1_a    : req0_a;
    assign w_b    = w_gnt ? req1_b    : req0_b;
    assign w_tag  = w_gnt ? req1_tag  : req0_tag;

    alu_arbiter_alu u_alu (
        .i_func (w_func),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_out  (w_alu_out),
        .o_err  (w_alu_err)
    );

    always_comb begin
        w_new     = '0;
        w_new.out = w_alu_out;
        w_new.id  = w_gnt;
        w_new.tag = RESP_TAG_W_MAX'(w_tag);
        w_new.err = w_alu_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BUF_EMPTY: if (w_push) w_state_nxt = BUF_ONE;
            BUF_ONE: begin
`ifdef ALU_ARBITER_SKID_EN
                if (w_push && !w_pop) w_state_nxt = BUF_TWO;
`endif
                if (!w_push && w_pop) w_state_nxt = BUF_EMPTY;
            end
            BUF_TWO:   if (!w_push && w_pop) w_state_nxt = BUF_ONE;
            default:   w_state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= 1'b1;
        end else if (w_push) begin
            r_last <= w_gnt;
        end
    end

`ifdef ALU_ARBITER_SKID_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop && (r_state == BUF_TWO)) begin
                r_head <= r_tail;
            end else if (w_push && ((r_state == BUF_EMPTY) || w_pop)) begin
                r_head <= w_new;
            end
            if (w_push && ((r_state == BUF_TWO) || ((r_state == BUF_ONE) && !w_pop))) begin
                r_tail <= w_new;
            end
        end
    end
`else
    // Single entry: a push only happens into an empty or simultaneously draining slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
        end else if (w_push) begin
            r_head <= w_new;
        end
    end
`endif

    assign resp_valid = (r_state != BUF_EMPTY);
    assign resp_out   = r_head.out;
    assign resp_id    = r_head.id;
    assign resp_tag   = TAG_W'(r_head.tag);
    assign resp_err   = r_head.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: queue-based reference model checked every cycle plus directed literal expectations.
module tb_alu_arbiter;

    localparam int TAG_W = 4;
`ifdef ALU_ARBITER_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_func = '0, req1_func = '0;
    logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             resp_valid, resp_ready = 1'b0;
    logic [31:0]      resp_out;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func(req0_func),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func(req1_func),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
        .resp_id(resp_id), .resp_tag(resp_tag), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]      out;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   m_last = 1;
    int   m_g;
    exp_t m_e;
    int   c_g;

    function automatic logic [31:0] m_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (f)
            4'd0: return ~(a | b);
            4'd1: return 32'($signed(a) >>> sh);
            4'd2: return a >> sh;
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a & b;
            4'd7: return a | b;
            4'd8: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_grant();
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_space();
        return (q.size() < DEPTH) || (resp_ready == 1'b1);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            m_last = 1;
        end else begin
            m_g = m_grant();
            if (resp_ready && q.size() > 0) void'(q.pop_front());
            if (m_g >= 0 && (q.size() < DEPTH)) begin
                if (m_g == 0) begin
                    m_e.out = m_alu(req0_func, req0_a, req0_b);
                    m_e.tag = req0_tag;
                    m_e.err = (req0_func > 4'd8);
                end else begin
                    m_e.out = m_alu(req1_func, req1_a, req1_b);
                    m_e.tag = req1_tag;
                    m_e.err = (req1_func > 4'd8);
                end
                m_e.id = (m_g == 1);
                q.push_back(m_e);
                m_last = m_g;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            c_g = m_grant();
            chk("req0_ready", 32'(req0_ready), 32'(c_g == 0 && m_space()));
            chk("req1_ready", 32'(req1_ready), 32'(c_g == 1 && m_space()));
            chk("resp_valid", 32'(resp_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("resp_out", resp_out, q[0].out);
                chk("resp_id",  32'(resp_id), 32'(q[0].id));
                chk("resp_tag", 32'(resp_tag), 32'(q[0].tag));
                chk("resp_err", 32'(resp_err), 32'(q[0].err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [3:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        if (p == 0) begin
            req0_valid = 1'b1; req0_func = f; req0_a = a; req0_b = b; req0_tag = t;
        end else begin
            req1_valid = 1'b1; req1_func = f; req1_a = a; req1_b = b; req1_tag = t;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string nm, input int p, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] t,
                          input logic [31:0] e_out, input logic e_err);
        idle();
        set_req(p, f, a, b, t);
        resp_ready = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk({nm, "_valid"}, 32'(resp_valid), 32'd1);
        chk({nm, "_out"}, resp_out, e_out);
        chk({nm, "_id"}, 32'(resp_id), 32'(p));
        chk({nm, "_tag"}, 32'(resp_tag), 32'(t));
        chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset state, with both requesters asserting to prove ready is held low.
        resetn = 1'b0;
        set_req(0, 4'd3, 32'd1, 32'd1, 4'd1);
        set_req(1, 4'd3, 32'd2, 32'd2, 4'd2);
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_out",   resp_out, 32'd0);
        chk("rst_resp_id",    32'(resp_id), 32'd0);
        chk("rst_resp_tag",   32'(resp_tag), 32'd0);
        chk("rst_resp_err",   32'(resp_err), 32'd0);
        idle();
        @(posedge clk); #1;
        resetn = 1'b1;
        step();

        single("add",     0, 4'd3,  32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
        single("illegal", 1, 4'hC,  32'd1, 32'd1, 4'd5, 32'd0, 1'b1);
        single("sub",     0, 4'd4,  32'd0, 32'd1, 4'd6, 32'hFFFF_FFFF, 1'b0);
        single("slt",     0, 4'd5,  32'd3, 32'd9, 4'd7, 32'd1, 1'b0);
        single("slt_neg", 1, 4'd5,  32'hFFFF_FFFF, 32'd0, 4'd8, 32'd1, 1'b0);
        single("nor",     1, 4'd0,  32'd0, 32'd0, 4'd9, 32'hFFFF_FFFF, 1'b0);
        single("sra",     0, 4'd1,  32'h8000_0000, 32'd4, 4'd10, 32'hF800_0000, 1'b0);
        single("srl",     1, 4'd2,  32'h8000_0000, 32'd4, 4'd11, 32'h0800_0000, 1'b0);
        single("and",     0, 4'd6,  32'h0000_F0F0, 32'h0000_FF00, 4'd12, 32'h0000_F000, 1'b0);
        single("or",      1, 4'd7,  32'h0000_F0F0, 32'h0000_FF00, 4'd13, 32'h0000_FFF0, 1'b0);
        single("xor",     0, 4'd8,  32'h0000_F0F0, 32'h0000_FF00, 4'd14, 32'h0000_0FF0, 1'b0);
        single("ill9",    0, 4'h9,  32'd4, 32'd4, 4'd15, 32'd0, 1'b1);

        // Fresh reset, then continuous contention: grants alternate starting with port 0.
        @(negedge clk); #2;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        set_req(0, 4'd3, 32'd10, 32'd1, 4'd1);
        set_req(1, 4'd8, 32'd6,  32'd3, 4'd2);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) idle();
            @(negedge clk);
            chk($sformatf("rr_id%0d", i), 32'(resp_id), 32'(i % 2));
        end
        step();
        step();

        // Consumer stalls under contention: buffer fills to its depth, head stays put.
        resp_ready = 1'b0;
        set_req(0, 4'd3, 32'd100, 32'd1, 4'd4);
        set_req(1, 4'd4, 32'd100, 32'd1, 4'd5);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc += int'(req0_valid && req0_ready) + int'(req1_valid && req1_ready);
            step();
        end
        @(negedge clk);
        chk("stall_accepts", 32'(acc), 32'(DEPTH));
        chk("stall_valid", 32'(resp_valid), 32'd1);
        chk("stall_out", resp_out, 32'd101);
        chk("stall_tag", 32'(resp_tag), 32'd4);
        idle();
        resp_ready = 1'b1;
        step();
        @(negedge clk);
`ifdef ALU_ARBITER_SKID_EN
        chk("drain2_valid", 32'(resp_valid), 32'd1);
        chk("drain2_out", resp_out, 32'd99);
        chk("drain2_id", 32'(resp_id), 32'd1);
`else
        chk("drain_empty", 32'(resp_valid), 32'd0);
`endif
        step();
        step();

        // Reset while holding entries: valid drops at once, then port 0 wins contention.
        resp_ready = 1'b0;
        set_req(0, 4'd6, 32'hFF, 32'h0F, 4'd7);
        set_req(1, 4'd7, 32'hF0, 32'h0F, 4'd8);
        repeat (3) step();
        idle();
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_out", resp_out, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        set_req(0, 4'd6, 32'hFF, 32'h0F, 4'd7);
        set_req(1, 4'd7, 32'hF0, 32'h0F, 4'd8);
        resp_ready = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk("post_rst_id", 32'(resp_id), 32'd0);
        chk("post_rst_out", resp_out, 32'h0000_000F);
        chk("post_rst_tag", 32'(resp_tag), 32'd7);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
